fir_bank_sequencer: RTL and testbench

//  Time-multiplexed controller for the hearing-aid filter bank: shares one external signed

---
 rtl/fir_bank_sequencer_if.sv | 46 ++++
 rtl/fir_bank_sequencer.sv | 145 ++++++++++++++
 tb/tb_fir_bank_sequencer.sv | 333 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fir_bank_sequencer_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | fir_bank_sequencer_if                                                      |
// | Sample, coefficient, multiplier and result signals of the FIR bank.        |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
interface fir_bank_sequencer_if #(
  parameter int NTAPS = 41,
  parameter int NCH   = 8,
  parameter int IW    = 16,
  parameter int TW    = 16
);
  localparam int c_chw  = $clog2(NCH);
  localparam int c_tapw = $clog2(NTAPS);

  logic signed [IW-1:0]    i_sample;
  logic                    i_sample_valid;
  logic                    o_sample_ready;
  logic                    i_cfg_we;
  logic [c_chw-1:0]        i_cfg_ch;
  logic [c_tapw-1:0]       i_cfg_tap;
  logic signed [TW-1:0]    i_cfg_coef;
  logic signed [IW-1:0]    o_mul_a;
  logic signed [TW-1:0]    o_mul_b;
  logic signed [IW+TW-1:0] i_mul_y;
  logic signed [31:0]      o_result;
  logic [c_chw-1:0]        o_result_ch;
  logic                    o_result_valid;
  logic                    i_result_ready;
  logic                    o_busy;

  modport slave (
    input  i_sample, i_sample_valid, i_cfg_we, i_cfg_ch, i_cfg_tap, i_cfg_coef,
           i_mul_y, i_result_ready,
    output o_sample_ready, o_mul_a, o_mul_b, o_result, o_result_ch, o_result_valid,
           o_busy
  );

  modport master (
    output i_sample, i_sample_valid, i_cfg_we, i_cfg_ch, i_cfg_tap, i_cfg_coef,
           i_mul_y, i_result_ready,
    input  o_sample_ready, o_mul_a, o_mul_b, o_result, o_result_ch, o_result_valid,
           o_busy
  );
endinterface
`default_nettype wire

// File: rtl/fir_bank_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | fir_bank_sequencer                                                         |
// | Shares one external multiplier across NCH FIR bands; circular delay line.  |
// | Option: FIR_BANK_SAT_EN saturates the result to signed 32 bits.            |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module fir_bank_sequencer #(
  parameter int NTAPS = 41,
  parameter int NCH   = 8,
  parameter int IW    = 16,
  parameter int TW    = 16,
  parameter int AW    = 38
) (
  input  wire logic          i_clk,
  input  wire logic          i_reset_n,
  fir_bank_sequencer_if.slave bus
);
  localparam int c_chw  = $clog2(NCH);
  localparam int c_tapw = $clog2(NTAPS);
  localparam int c_pw   = IW + TW;
  localparam logic [c_tapw-1:0] c_last_tap = c_tapw'(NTAPS - 1);
  localparam logic [c_tapw-1:0] c_ntaps_w  = c_tapw'(NTAPS);
  localparam logic [c_chw-1:0]  c_last_ch  = c_chw'(NCH - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MAC  = 2'd1,
    ST_OUT  = 2'd2
  } state_t;

  state_t               r_state;
  logic signed [IW-1:0] r_buf  [NTAPS];
  logic signed [TW-1:0] r_coef [NCH][NTAPS];
  logic [c_tapw-1:0]    r_wp;
  logic [c_tapw-1:0]    r_newest;
  logic [c_chw-1:0]     r_ch;
  logic [c_tapw-1:0]    r_k;
  logic signed [AW-1:0] r_acc;
  logic                 r_sample_ready;
  logic                 r_result_valid;
  logic                 r_busy;

  logic [c_tapw-1:0]    w_rd_idx;
  logic signed [AW-1:0] w_y_ext;
  logic                 w_cfg_hit;
  logic [31:0]          w_result;

  // Modular subtraction; intermediate wrap at 2^c_tapw cancels out.
  assign w_rd_idx = (r_newest >= r_k) ? (r_newest - r_k) : (r_newest + c_ntaps_w - r_k);
  assign w_y_ext  = {{(AW-c_pw){bus.i_mul_y[c_pw-1]}}, bus.i_mul_y};
  assign w_cfg_hit = bus.i_cfg_we && (r_state == ST_IDLE) &&
                     (int'(bus.i_cfg_ch) < NCH) && (int'(bus.i_cfg_tap) < NTAPS);

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_state        <= ST_IDLE;
      r_wp           <= '0;
      r_newest       <= '0;
      r_ch           <= '0;
      r_k            <= '0;
      r_acc          <= '0;
      r_sample_ready <= 1'b1;
      r_result_valid <= 1'b0;
      r_busy         <= 1'b0;
      for (int t = 0; t < NTAPS; t++) begin
        r_buf[t] <= '0;
      end
      for (int c = 0; c < NCH; c++) begin
        for (int t = 0; t < NTAPS; t++) begin
          r_coef[c][t] <= '0;
        end
      end
    end else begin
      if (w_cfg_hit) begin
        r_coef[bus.i_cfg_ch][bus.i_cfg_tap] <= bus.i_cfg_coef;
      end
      case (r_state)
        ST_IDLE: begin
          if (bus.i_sample_valid) begin
            r_buf[r_wp]    <= bus.i_sample;
            r_newest       <= r_wp;
            r_wp           <= (r_wp == c_last_tap) ? '0 : r_wp + 1'b1;
            r_ch           <= '0;
            r_k            <= '0;
            r_state        <= ST_MAC;
            r_sample_ready <= 1'b0;
            r_busy         <= 1'b1;
          end
        end
        ST_MAC: begin
          r_acc <= (r_k == '0) ? w_y_ext : r_acc + w_y_ext;
          if (r_k == c_last_tap) begin
            r_state        <= ST_OUT;
            r_result_valid <= 1'b1;
          end else begin
            r_k <= r_k + 1'b1;
          end
        end
        ST_OUT: begin
          if (bus.i_result_ready) begin
            r_result_valid <= 1'b0;
            if (r_ch == c_last_ch) begin
              r_state        <= ST_IDLE;
              r_sample_ready <= 1'b1;
              r_busy         <= 1'b0;
            end else begin
              r_ch    <= r_ch + 1'b1;
              r_k     <= '0;
              r_state <= ST_MAC;
            end
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef FIR_BANK_SAT_EN
  always_comb begin
    w_result = r_acc[31:0];
    if (!r_acc[AW-1] && (|r_acc[AW-2:31])) begin
      w_result = 32'h7FFF_FFFF;
    end else if (r_acc[AW-1] && !(&r_acc[AW-2:31])) begin
      w_result = 32'h8000_0000;
    end
  end
`else
  logic w_unused_acc_hi;
  assign w_unused_acc_hi = ^r_acc[AW-1:32];
  assign w_result        = r_acc[31:0];
`endif

  // Operands held at zero outside MAC so the multiplier does not toggle.
  assign bus.o_mul_a        = (r_state == ST_MAC) ? r_buf[w_rd_idx]  : '0;
  assign bus.o_mul_b        = (r_state == ST_MAC) ? r_coef[r_ch][r_k] : '0;
  assign bus.o_result       = w_result;
  assign bus.o_result_ch    = r_ch;
  assign bus.o_result_valid = r_result_valid;
  assign bus.o_sample_ready = r_sample_ready;
  assign bus.o_busy         = r_busy;
endmodule
`default_nettype wire

// File: tb/tb_fir_bank_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_fir_bank_sequencer                                                      |
// | Directed bench for fir_bank_sequencer with a behavioural exact multiplier. |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_fir_bank_sequencer;
  logic clk;
  logic reset_n;
  int   total;
  int   bad;

  logic [31:0] res     [8];
  logic [2:0]  res_ch  [8];
  int          res_cyc [8];

  fir_bank_sequencer_if #(.NTAPS(41), .NCH(8), .IW(16), .TW(16)) bus ();

  fir_bank_sequencer #(.NTAPS(41), .NCH(8), .IW(16), .TW(16), .AW(38)) dut (
    .i_clk     (clk),
    .i_reset_n (reset_n),
    .bus       (bus)
  );

  assign bus.i_mul_y = $signed(bus.o_mul_a) * $signed(bus.o_mul_b);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #800000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    reset_n = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
  endtask

  task automatic write_coef(input logic [2:0] ch, input logic [5:0] tap, input logic [15:0] val);
    bus.i_cfg_we   = 1'b1;
    bus.i_cfg_ch   = ch;
    bus.i_cfg_tap  = tap;
    bus.i_cfg_coef = val;
    tick();
    bus.i_cfg_we   = 1'b0;
  endtask

  task automatic fill_coefs(input logic [15:0] val);
    for (int c = 0; c < 8; c++) begin
      for (int t = 0; t < 41; t++) begin
        write_coef(3'(c), 6'(t), val);
      end
    end
  endtask

  // One full frame; optional cfg write in the accept cycle or in frame cycle 5.
  task automatic run_frame(input logic [15:0] s, input bit acc_we, input bit busy_we,
                           input logic [2:0] wch, input logic [5:0] wtap, input logic [15:0] wcoef);
    int cyc;
    int n;
    bus.i_sample       = s;
    bus.i_sample_valid = 1'b1;
    bus.i_cfg_ch       = wch;
    bus.i_cfg_tap      = wtap;
    bus.i_cfg_coef     = wcoef;
    bus.i_cfg_we       = acc_we;
    cyc = 0;
    while (bus.o_sample_ready !== 1'b1 && cyc < 500) begin
      tick();
      cyc++;
    end
    total++;
    if (bus.o_sample_ready !== 1'b1) begin
      bad++;
      $display("FAIL accept_wait: o_sample_ready=%b required 1", bus.o_sample_ready);
    end
    tick();
    bus.i_sample_valid = 1'b0;
    bus.i_cfg_we       = 1'b0;
    n   = 0;
    cyc = 1;
    while (n < 8 && cyc < 1000) begin
      bus.i_cfg_we = (busy_we && cyc == 5);
      if (bus.o_result_valid === 1'b1 && bus.i_result_ready === 1'b1) begin
        res[n]     = bus.o_result;
        res_ch[n]  = bus.o_result_ch;
        res_cyc[n] = cyc;
        n++;
      end
      tick();
      cyc++;
    end
    bus.i_cfg_we = 1'b0;
    total++;
    if (n != 8) begin
      bad++;
      $display("FAIL frame_results: got %0d results required 8", n);
    end
  endtask

  task automatic test_reset();
    apply_reset();
    total += 7;
    if (bus.o_sample_ready !== 1'b1) begin bad++; $display("FAIL rst_ready: got %b required 1", bus.o_sample_ready); end
    if (bus.o_busy !== 1'b0)         begin bad++; $display("FAIL rst_busy: got %b required 0", bus.o_busy); end
    if (bus.o_result_valid !== 1'b0) begin bad++; $display("FAIL rst_valid: got %b required 0", bus.o_result_valid); end
    if (bus.o_result !== 32'd0)      begin bad++; $display("FAIL rst_result: got %h required 0", bus.o_result); end
    if (bus.o_result_ch !== 3'd0)    begin bad++; $display("FAIL rst_ch: got %0d required 0", bus.o_result_ch); end
    if (bus.o_mul_a !== 16'd0)       begin bad++; $display("FAIL rst_mul_a: got %h required 0", bus.o_mul_a); end
    if (bus.o_mul_b !== 16'd0)       begin bad++; $display("FAIL rst_mul_b: got %h required 0", bus.o_mul_b); end
  endtask

  task automatic test_single_tap();
    write_coef(3'd0, 6'd0, 16'd1);
    run_frame(16'd100, 1'b0, 1'b0, 3'd0, 6'd0, 16'd0);
    for (int b = 0; b < 8; b++) begin
      total += 3;
      if (res[b] !== ((b == 0) ? 32'd100 : 32'd0)) begin
        bad++; $display("FAIL single_tap_value band=%0d got=%h required=%h", b, res[b], (b == 0) ? 32'd100 : 32'd0);
      end
      if (res_ch[b] !== 3'(b)) begin
        bad++; $display("FAIL single_tap_ch slot=%0d got=%0d required=%0d", b, res_ch[b], b);
      end
      if (res_cyc[b] != 42 + 42 * b) begin
        bad++; $display("FAIL single_tap_latency band=%0d got=%0d required=%0d", b, res_cyc[b], 42 + 42 * b);
      end
    end
    total += 2;
    if (bus.o_sample_ready !== 1'b1) begin bad++; $display("FAIL frame_end_ready: got %b required 1", bus.o_sample_ready); end
    if (bus.o_busy !== 1'b0)         begin bad++; $display("FAIL frame_end_busy: got %b required 0", bus.o_busy); end
  endtask

  task automatic test_all_ones();
    logic [31:0] exp_v [3];
    exp_v[0] = 32'd1; exp_v[1] = 32'd3; exp_v[2] = 32'd6;
    apply_reset();
    fill_coefs(16'd1);
    for (int f = 0; f < 3; f++) begin
      run_frame(16'(f + 1), 1'b0, 1'b0, 3'd0, 6'd0, 16'd0);
      for (int b = 0; b < 8; b++) begin
        total++;
        if (res[b] !== exp_v[f]) begin
          bad++; $display("FAIL all_ones frame=%0d band=%0d got=%h required=%h", f, b, res[b], exp_v[f]);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    int  cyc;
    int  n;
    bit  seen;
    bus.i_sample       = 16'd4;
    bus.i_sample_valid = 1'b1;
    cyc = 0;
    while (bus.o_sample_ready !== 1'b1 && cyc < 500) begin tick(); cyc++; end
    tick();
    bus.i_sample_valid = 1'b0;
    seen = 1'b0;
    cyc  = 0;
    while (!seen && cyc < 1000) begin
      if (bus.o_result_valid === 1'b1 && bus.o_result_ch === 3'd2) seen = 1'b1;
      tick();
      cyc++;
    end
    bus.i_result_ready = 1'b0;
    cyc = 0;
    while (bus.o_result_valid !== 1'b1 && cyc < 100) begin tick(); cyc++; end
    total++;
    if (!seen || bus.o_result_valid !== 1'b1 || bus.o_result_ch !== 3'd3) begin
      bad++; $display("FAIL bp_reach_band3: valid=%b ch=%0d required valid=1 ch=3", bus.o_result_valid, bus.o_result_ch);
    end
    bus.i_sample       = 16'd999;
    bus.i_sample_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      total++;
      if (bus.o_result !== 32'd10 || bus.o_result_ch !== 3'd3 || bus.o_result_valid !== 1'b1 ||
          bus.o_sample_ready !== 1'b0 || bus.o_busy !== 1'b1 || bus.o_mul_a !== 16'd0 || bus.o_mul_b !== 16'd0) begin
        bad++;
        $display("FAIL bp_hold cycle=%0d result=%h ch=%0d valid=%b ready=%b busy=%b mul_a=%h mul_b=%h required 0000000a,3,1,0,1,0,0",
                 i, bus.o_result, bus.o_result_ch, bus.o_result_valid, bus.o_sample_ready, bus.o_busy, bus.o_mul_a, bus.o_mul_b);
      end
      tick();
    end
    bus.i_sample_valid = 1'b0;
    bus.i_result_ready = 1'b1;
    n   = 0;
    cyc = 0;
    while (n < 5 && cyc < 500) begin
      if (bus.o_result_valid === 1'b1) begin
        total++;
        if (bus.o_result !== 32'd10 || bus.o_result_ch !== 3'(3 + n)) begin
          bad++; $display("FAIL bp_resume slot=%0d got=%h ch=%0d required=0000000a ch=%0d", n, bus.o_result, bus.o_result_ch, 3 + n);
        end
        n++;
      end
      tick();
      cyc++;
    end
    total++;
    if (n != 5) begin bad++; $display("FAIL bp_resume_count: got %0d required 5", n); end
    run_frame(16'd5, 1'b0, 1'b0, 3'd0, 6'd0, 16'd0);
    for (int b = 0; b < 8; b++) begin
      total++;
      if (res[b] !== 32'd15) begin
        bad++; $display("FAIL bp_no_accept band=%0d got=%h required=%h", b, res[b], 32'd15);
      end
    end
  endtask

  task automatic test_cfg_guard();
    logic [31:0] e;
    run_frame(16'd6, 1'b0, 1'b1, 3'd2, 6'd5, 16'd100);
    for (int b = 0; b < 8; b++) begin
      total++;
      if (res[b] !== 32'd21) begin
        bad++; $display("FAIL cfg_busy_write band=%0d got=%h required=%h", b, res[b], 32'd21);
      end
    end
    write_coef(3'd2, 6'd41, 16'd100);
    run_frame(16'd7, 1'b1, 1'b0, 3'd5, 6'd0, 16'd3);
    for (int b = 0; b < 8; b++) begin
      e = (b == 5) ? 32'd42 : 32'd28;
      total++;
      if (res[b] !== e) begin
        bad++; $display("FAIL cfg_range_and_same_cycle band=%0d got=%h required=%h", b, res[b], e);
      end
    end
  endtask

  task automatic test_saturation();
    logic [31:0] e41;
    logic [31:0] e40;
`ifdef FIR_BANK_SAT_EN
    e41 = 32'h7FFF_FFFF;
    e40 = 32'h7FFF_FFFF;
`else
    e41 = 32'h3FD7_0029;
    e40 = 32'hFFD8_0028;
`endif
    apply_reset();
    fill_coefs(16'h7FFF);
    for (int f = 0; f < 41; f++) begin
      run_frame(16'h7FFF, 1'b0, 1'b0, 3'd0, 6'd0, 16'd0);
    end
    for (int b = 0; b < 8; b++) begin
      total++;
      if (res[b] !== e41) begin
        bad++; $display("FAIL sat_full band=%0d got=%h required=%h", b, res[b], e41);
      end
    end
    run_frame(16'd0, 1'b0, 1'b0, 3'd0, 6'd0, 16'd0);
    for (int b = 0; b < 8; b++) begin
      total++;
      if (res[b] !== e40) begin
        bad++; $display("FAIL sat_wrap_wp band=%0d got=%h required=%h", b, res[b], e40);
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    int cyc;
    bus.i_sample       = 16'h1234;
    bus.i_sample_valid = 1'b1;
    cyc = 0;
    while (bus.o_sample_ready !== 1'b1 && cyc < 500) begin tick(); cyc++; end
    tick();
    bus.i_sample_valid = 1'b0;
    for (int c = 1; c < 180; c++) tick();
    total++;
    if (bus.o_busy !== 1'b1 || bus.o_result_valid !== 1'b0 || bus.o_result_ch !== 3'd4) begin
      bad++; $display("FAIL mid_band4: busy=%b valid=%b ch=%0d required 1,0,4", bus.o_busy, bus.o_result_valid, bus.o_result_ch);
    end
    reset_n = 1'b0;
    tick();
    total += 7;
    if (bus.o_sample_ready !== 1'b1) begin bad++; $display("FAIL mid_rst_ready: got %b required 1", bus.o_sample_ready); end
    if (bus.o_busy !== 1'b0)         begin bad++; $display("FAIL mid_rst_busy: got %b required 0", bus.o_busy); end
    if (bus.o_result_valid !== 1'b0) begin bad++; $display("FAIL mid_rst_valid: got %b required 0", bus.o_result_valid); end
    if (bus.o_result !== 32'd0)      begin bad++; $display("FAIL mid_rst_result: got %h required 0", bus.o_result); end
    if (bus.o_result_ch !== 3'd0)    begin bad++; $display("FAIL mid_rst_ch: got %0d required 0", bus.o_result_ch); end
    if (bus.o_mul_a !== 16'd0)       begin bad++; $display("FAIL mid_rst_mul_a: got %h required 0", bus.o_mul_a); end
    if (bus.o_mul_b !== 16'd0)       begin bad++; $display("FAIL mid_rst_mul_b: got %h required 0", bus.o_mul_b); end
    reset_n = 1'b1;
    run_frame(16'h0100, 1'b0, 1'b0, 3'd0, 6'd0, 16'd0);
    for (int b = 0; b < 8; b++) begin
      total++;
      if (res[b] !== 32'd0) begin
        bad++; $display("FAIL coef_cleared band=%0d got=%h required=0", b, res[b]);
      end
    end
    for (int t = 0; t < 41; t++) write_coef(3'd0, 6'(t), 16'd1);
    run_frame(16'd1, 1'b0, 1'b0, 3'd0, 6'd0, 16'd0);
    for (int b = 0; b < 8; b++) begin
      total++;
      if (res[b] !== ((b == 0) ? 32'd257 : 32'd0)) begin
        bad++; $display("FAIL delay_cleared band=%0d got=%h required=%h", b, res[b], (b == 0) ? 32'd257 : 32'd0);
      end
    end
  endtask

  initial begin
    total              = 0;
    bad                = 0;
    reset_n            = 1'b0;
    bus.i_sample       = '0;
    bus.i_sample_valid = 1'b0;
    bus.i_cfg_we       = 1'b0;
    bus.i_cfg_ch       = '0;
    bus.i_cfg_tap      = '0;
    bus.i_cfg_coef     = '0;
    bus.i_result_ready = 1'b1;
    test_reset();
    test_single_tap();
    test_all_ones();
    test_backpressure();
    test_cfg_guard();
    test_saturation();
    test_reset_mid_frame();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
`default_nettype wire
